// File: rtl/sc_speed_tickdecoder_if.sv
// sc_speed_tickdecoder_if
//   Bundles the tick-decoder stream input, its synchronous clear and the
//   published measurement so that the decoder and its consumer share one port.
//   master : drives tick/clear and reads the measurement
//   slave  : the decoder itself
//   Signals:
//     SC_SpeedDECODER_tick_InLow     tick stream, rising edge marks one period
//     SC_SpeedDECODER_clear_InHigh   synchronous clear back to IDLE
//     SC_SpeedDECODER_period_OutBUS  last measured period in CLOCK_50 cycles
//     SC_SpeedDECODER_band_OutBUS    0 stopped, 1 slow, 2 mid, 3 fast
//     SC_SpeedDECODER_valid_OutHigh  one-cycle strobe on period/band update
//     SC_SpeedDECODER_timeout_OutHigh level, stream stopped
//     SC_SpeedDECODER_glitch_OutBUS  saturating count of rejected edges
interface sc_speed_tickdecoder_if #(
  parameter int unsigned CNT_WIDTH = 26
);
  logic                 SC_SpeedDECODER_tick_InLow;
  logic                 SC_SpeedDECODER_clear_InHigh;
  logic [CNT_WIDTH-1:0] SC_SpeedDECODER_period_OutBUS;
  logic [1:0]           SC_SpeedDECODER_band_OutBUS;
  logic                 SC_SpeedDECODER_valid_OutHigh;
  logic                 SC_SpeedDECODER_timeout_OutHigh;
  logic [7:0]           SC_SpeedDECODER_glitch_OutBUS;

  modport master (
    output SC_SpeedDECODER_tick_InLow,
    output SC_SpeedDECODER_clear_InHigh,
    input  SC_SpeedDECODER_period_OutBUS,
    input  SC_SpeedDECODER_band_OutBUS,
    input  SC_SpeedDECODER_valid_OutHigh,
    input  SC_SpeedDECODER_timeout_OutHigh,
    input  SC_SpeedDECODER_glitch_OutBUS
  );

  modport slave (
    input  SC_SpeedDECODER_tick_InLow,
    input  SC_SpeedDECODER_clear_InHigh,
    output SC_SpeedDECODER_period_OutBUS,
    output SC_SpeedDECODER_band_OutBUS,
    output SC_SpeedDECODER_valid_OutHigh,
    output SC_SpeedDECODER_timeout_OutHigh,
    output SC_SpeedDECODER_glitch_OutBUS
  );
endinterface

// File: rtl/sc_speed_tickdecoder.sv
// sc_speed_tickdecoder
//   Receiving end of the speed-to-tick-rate timer. Counts CLOCK_50 cycles
//   between rising edges of the tick stream, rejects edges that arrive too
//   early (glitches), detects a stopped stream and publishes the period, a
//   speed band, a valid strobe and status.
//   Ports:
//     SC_SpeedDECODER_CLOCK_50      system clock
//     SC_SpeedDECODER_RESET_InHigh  asynchronous active-high reset
//     decIf (slave modport)         tick/clear in, period/band/valid/timeout/glitch out
//   Build option:
//     SC_SPEEDDECODER_AVG_EN  when defined, the published period is the mean of
//                             the last four accepted periods and the band is
//                             classified on that mean.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | counter held, waiting for a reference edge
//   MEASURE | counting cycles since the last accepted edge
//   STOPPED | no edge within TIMEOUT_CYCLES, outputs held, waiting for edge
module sc_speed_tickdecoder #(
  parameter int unsigned CNT_WIDTH      = 26,
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned MIN_PERIOD     = 1000,
  parameter int unsigned BAND3_MAX      = 10000000,
  parameter int unsigned BAND2_MAX      = 14000000
) (
  input  logic                   SC_SpeedDECODER_CLOCK_50,
  input  logic                   SC_SpeedDECODER_RESET_InHigh,
  sc_speed_tickdecoder_if.slave  decIf
);

  if (!((MIN_PERIOD < BAND3_MAX) && (BAND3_MAX < BAND2_MAX) &&
        (BAND2_MAX < TIMEOUT_CYCLES))) begin : gParamOrderCheck
    $error("sc_speed_tickdecoder: need MIN_PERIOD < BAND3_MAX < BAND2_MAX < TIMEOUT_CYCLES");
  end
  if (64'(TIMEOUT_CYCLES) >= (64'd1 << CNT_WIDTH)) begin : gTimeoutWidthCheck
    $error("sc_speed_tickdecoder: TIMEOUT_CYCLES does not fit in CNT_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] MIN_C     = CNT_WIDTH'(MIN_PERIOD);
  localparam logic [CNT_WIDTH-1:0] BAND3_C   = CNT_WIDTH'(BAND3_MAX);
  localparam logic [CNT_WIDTH-1:0] BAND2_C   = CNT_WIDTH'(BAND2_MAX);
  localparam logic [CNT_WIDTH-1:0] ONE_C     = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STOPPED = 2'd2
  } stateT;

  stateT                state;
  logic                 tickQ;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] periodReg;
  logic [1:0]           bandReg;
  logic                 validReg;
  logic                 timeoutReg;
  logic [7:0]           glitchReg;

  logic                 tick;
  logic                 clear;
  logic                 rise;
  logic [CNT_WIDTH-1:0] measPeriod;

  assign tick  = decIf.SC_SpeedDECODER_tick_InLow;
  assign clear = decIf.SC_SpeedDECODER_clear_InHigh;
  assign rise  = tick & ~tickQ;

  function automatic logic [1:0] bandOf(input logic [CNT_WIDTH-1:0] p);
    if (p <= BAND3_C)      return 2'd3;
    else if (p <= BAND2_C) return 2'd2;
    else                   return 2'd1;
  endfunction

`ifdef SC_SPEEDDECODER_AVG_EN
  // The incoming measurement is the newest of the four entries; only the
  // three older ones need storage.
  logic [CNT_WIDTH-1:0] hist [3];
  logic                 histFull;
  logic [CNT_WIDTH+1:0] avgSum;

  always_comb begin
    avgSum = {count, 2'b00};
    if (histFull) begin
      avgSum = {2'b00, count} + {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]};
    end
  end

  assign measPeriod = avgSum[CNT_WIDTH+1:2];
`else
  assign measPeriod = count;
`endif

  always_ff @(posedge SC_SpeedDECODER_CLOCK_50 or posedge SC_SpeedDECODER_RESET_InHigh) begin
    if (SC_SpeedDECODER_RESET_InHigh) begin
      state      <= IDLE;
      tickQ      <= 1'b0;
      count      <= '0;
      periodReg  <= '0;
      bandReg    <= 2'd0;
      validReg   <= 1'b0;
      timeoutReg <= 1'b0;
      glitchReg  <= 8'd0;
`ifdef SC_SPEEDDECODER_AVG_EN
      histFull   <= 1'b0;
      for (int i = 0; i < 3; i++) hist[i] <= '0;
`endif
    end else begin
      tickQ    <= tick;
      validReg <= 1'b0;
      if (clear) begin
        state      <= IDLE;
        count      <= '0;
        periodReg  <= '0;
        bandReg    <= 2'd0;
        timeoutReg <= 1'b0;
        glitchReg  <= 8'd0;
`ifdef SC_SPEEDDECODER_AVG_EN
        histFull   <= 1'b0;
        for (int i = 0; i < 3; i++) hist[i] <= '0;
`endif
      end else begin
        case (state)
          IDLE, STOPPED: begin
            // Any edge here is only a reference point for the next period.
            if (rise) begin
              state <= MEASURE;
              count <= ONE_C;
            end
          end
          MEASURE: begin
            // An edge coinciding with the timeout count is still a valid
            // measurement, so the edge branches come first.
            if (rise && (count >= MIN_C)) begin
              periodReg  <= measPeriod;
              bandReg    <= bandOf(measPeriod);
              validReg   <= 1'b1;
              timeoutReg <= 1'b0;
              count      <= ONE_C;
`ifdef SC_SPEEDDECODER_AVG_EN
              histFull <= 1'b1;
              if (histFull) begin
                hist[0] <= count;
                hist[1] <= hist[0];
                hist[2] <= hist[1];
              end else begin
                for (int i = 0; i < 3; i++) hist[i] <= count;
              end
`endif
            end else if (rise) begin
              if (glitchReg != 8'hFF) glitchReg <= glitchReg + 8'd1;
              count <= count + ONE_C;
            end else if (count == TIMEOUT_C) begin
              state      <= STOPPED;
              periodReg  <= TIMEOUT_C;
              bandReg    <= 2'd0;
              validReg   <= 1'b1;
              timeoutReg <= 1'b1;
`ifdef SC_SPEEDDECODER_AVG_EN
              histFull <= 1'b0;
              for (int i = 0; i < 3; i++) hist[i] <= '0;
`endif
            end else begin
              count <= count + ONE_C;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign decIf.SC_SpeedDECODER_period_OutBUS   = periodReg;
  assign decIf.SC_SpeedDECODER_band_OutBUS     = bandReg;
  assign decIf.SC_SpeedDECODER_valid_OutHigh   = validReg;
  assign decIf.SC_SpeedDECODER_timeout_OutHigh = timeoutReg;
  assign decIf.SC_SpeedDECODER_glitch_OutBUS   = glitchReg;

endmodule
